// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset controller.
// The optional TRAP state exists only when MC_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_MOVWB
`ifdef MC_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_MOVS  = 6'b010000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // AOP_NONE keeps alu_control at zero in states that do not use the ALU.
    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10,
        AOP_NONE  = 2'b11
    } alu_op_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared memory port handshake between the controller (master) and memory (slave).
interface multicycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_req, output mem_write, output i_or_d, input mem_ready);
    modport slave  (input mem_req, input mem_write, input i_or_d, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU control: fixed add/sub from the FSM, or funct-driven for R-type.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = '0;
        case (alu_op)
            AOP_ADD: alu_control = ALU_ADD;
            AOP_SUB: alu_control = ALU_SUB;
            AOP_FUNCT: begin
                case (funct)
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencing FSM; Moore outputs from state plus opcode/funct/mem_ready.
// Optional feature: MC_ILLEGAL_TRAP_EN routes unknown opcodes to a sticky TRAP state.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    multicycle_controller_if.master mem,
    output logic       ir_write,
    output logic       pc_en,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_src,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t  state, next_state;
    alu_op_t alu_op;
    logic    pc_write, branch;
    logic    mem_req, mem_write, i_or_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        next_state = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = AOP_NONE;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        reg_src    = 1'b0;
        instr_done = 1'b0;
        // Reset holds every control at zero so nothing is written during the reset cycle.
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = AOP_ADD;
                    if (mem.mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    alu_op    = AOP_ADD;
                    case (opcode)
                        OP_RTYPE:     next_state = S_EXEC;
                        OP_LW, OP_SW: next_state = S_MEMADR;
                        OP_BEQ:       next_state = S_BRANCH;
                        OP_ADDI:      next_state = S_ADDIEX;
                        OP_J:         next_state = S_JUMP;
                        OP_MOVS:      next_state = S_MOVWB;
`ifdef MC_ILLEGAL_TRAP_EN
                        default:      next_state = S_TRAP;
`else
                        default:      next_state = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = AOP_ADD;
                    next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                    if (mem.mem_ready) next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem.mem_ready) begin
                        instr_done = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = AOP_FUNCT;
                    next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = AOP_SUB;
                    branch     = 1'b1;
                    pc_src     = PCSRC_ALUOUT;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRCB_IMM;
                    alu_op     = AOP_ADD;
                    next_state = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = PCSRC_JUMP;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
                S_MOVWB: begin
                    reg_write  = 1'b1;
                    reg_src    = 1'b1;
                    instr_done = 1'b1;
                    next_state = S_FETCH;
                end
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP: next_state = S_TRAP;
`endif
                default: next_state = S_FETCH;
            endcase
        end
    end

    assign pc_en         = pc_write | (branch & zero);
    assign mem.mem_req   = mem_req;
    assign mem.mem_write = mem_write;
    assign mem.i_or_d    = i_or_d;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (alu_control)
    );

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Set on the DECODE->TRAP edge so the flag is already visible in the first TRAP cycle.
    always_ff @(posedge clk) begin
        if (rst)                      illegal_q <= 1'b0;
        else if (next_state == S_TRAP) illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output signatures against hand-derived values.
module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_src;
        logic       instr_done;
    } sig_t;

    //                            req wr iod irw pce pcs asa asb alu rdst m2r rw rsrc done
    localparam sig_t ZERO       = 18'b0_0_0_0_0_00_0_00_000_0_0_0_0_0;
    localparam sig_t FETCH_WAIT = 18'b1_0_0_0_0_00_0_01_010_0_0_0_0_0;
    localparam sig_t FETCH_GO   = 18'b1_0_0_1_1_00_0_01_010_0_0_0_0_0;
    localparam sig_t DECODE     = 18'b0_0_0_0_0_00_0_11_010_0_0_0_0_0;
    localparam sig_t EXEC_BASE  = 18'b0_0_0_0_0_00_1_00_000_0_0_0_0_0;
    localparam sig_t ALUWB      = 18'b0_0_0_0_0_00_0_00_000_1_0_1_0_1;
    localparam sig_t MEMADR     = 18'b0_0_0_0_0_00_1_10_010_0_0_0_0_0;
    localparam sig_t MEMRD      = 18'b1_0_1_0_0_00_0_00_000_0_0_0_0_0;
    localparam sig_t MEMWB      = 18'b0_0_0_0_0_00_0_00_000_0_1_1_0_1;
    localparam sig_t MEMWR_WAIT = 18'b1_1_1_0_0_00_0_00_000_0_0_0_0_0;
    localparam sig_t MEMWR_GO   = 18'b1_1_1_0_0_00_0_00_000_0_0_0_0_1;
    localparam sig_t BR_TAKEN   = 18'b0_0_0_0_1_01_1_00_110_0_0_0_0_1;
    localparam sig_t BR_NOT     = 18'b0_0_0_0_0_01_1_00_110_0_0_0_0_1;
    localparam sig_t ADDIWB     = 18'b0_0_0_0_0_00_0_00_000_0_0_1_0_1;
    localparam sig_t JUMP       = 18'b0_0_0_0_1_10_0_00_000_0_0_0_0_1;
    localparam sig_t MOVWB      = 18'b0_0_0_0_0_00_0_00_000_0_0_1_1_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       ir_write, pc_en, alu_src_a, reg_dst, mem_to_reg, reg_write, reg_src;
    logic       instr_done, illegal_op;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_control;
    sig_t       got;
    int         n_asserts = 0;
    int         n_fail = 0;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem         (bus),
        .ir_write    (ir_write),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .reg_src     (reg_src),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    assign got = {bus.mem_req, bus.mem_write, bus.i_or_d, ir_write, pc_en, pc_src, alu_src_a,
                  alu_src_b, alu_control, reg_dst, mem_to_reg, reg_write, reg_src, instr_done};

    task automatic check(input string tag, input logic [17:0] observed, input logic [17:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Inputs are changed at the falling edge; outputs are checked 1 ns later, then one cycle passes.
    task automatic step(input string tag, input sig_t expected);
        #1 check(tag, got, expected);
        @(negedge clk);
    endtask

    task automatic check_illegal(input string tag, input logic expected);
        #1 check(tag, {17'b0, illegal_op}, {17'b0, expected});
    endtask

    function automatic sig_t exec_sig(input logic [2:0] alu);
        sig_t s = EXEC_BASE;
        s.alu_control = alu;
        return s;
    endfunction

    logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] alu_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", got, ZERO);
        check_illegal("reset_illegal", 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // R-type: add, sub, and, or, slt and an unknown funct (falls back to add)
        for (int i = 0; i < 6; i++) begin
            opcode = 6'b000000; funct = fn_tab[i];
            step("rt_fetch", FETCH_GO);
            step("rt_decode", DECODE);
            step("rt_exec", exec_sig(alu_tab[i]));
            step("rt_aluwb", ALUWB);
        end

        // lw with three wait cycles in MEMRD: 8 cycles total
        opcode = 6'b100011;
        step("lw_fetch", FETCH_GO);
        bus.mem_ready = 1'b0;
        step("lw_decode", DECODE);
        step("lw_memadr", MEMADR);
        repeat (3) step("lw_memrd_wait", MEMRD);
        bus.mem_ready = 1'b1;
        step("lw_memrd_done", MEMRD);
        step("lw_memwb", MEMWB);

        // fetch wait then beq taken / not taken
        opcode = 6'b000100; zero = 1'b1; bus.mem_ready = 1'b0;
        step("beq_fetch_wait", FETCH_WAIT);
        bus.mem_ready = 1'b1;
        step("beq_t_fetch", FETCH_GO);
        step("beq_t_decode", DECODE);
        step("beq_taken", BR_TAKEN);
        zero = 1'b0;
        step("beq_n_fetch", FETCH_GO);
        step("beq_n_decode", DECODE);
        step("beq_not_taken", BR_NOT);

        // j, addi, MOVS back-to-back
        opcode = 6'b000010;
        step("j_fetch", FETCH_GO);
        step("j_decode", DECODE);
        step("j_jump", JUMP);
        opcode = 6'b001000;
        step("addi_fetch", FETCH_GO);
        step("addi_decode", DECODE);
        step("addi_ex", MEMADR);
        step("addi_wb", ADDIWB);
        opcode = 6'b010000;
        step("movs_fetch", FETCH_GO);
        step("movs_decode", DECODE);
        step("movs_wb", MOVWB);

        // sw with zero wait: 4 cycles
        opcode = 6'b101011;
        step("sw_fetch", FETCH_GO);
        step("sw_decode", DECODE);
        step("sw_memadr", MEMADR);
        step("sw_memwr", MEMWR_GO);

        // sw abandoned by reset during the MEMWR wait
        step("swr_fetch", FETCH_GO);
        step("swr_decode", DECODE);
        step("swr_memadr", MEMADR);
        bus.mem_ready = 1'b0;
        step("swr_wait", MEMWR_WAIT);
        step("swr_wait2", MEMWR_WAIT);
        rst = 1'b1;
        step("swr_reset_cycle", ZERO);
        rst = 1'b0;
        step("swr_post_reset_fetch", FETCH_WAIT);
        bus.mem_ready = 1'b1;

        // unknown opcode
        opcode = 6'b111111;
        step("ill_fetch", FETCH_GO);
        step("ill_decode", DECODE);
`ifdef MC_ILLEGAL_TRAP_EN
        repeat (3) begin
            check_illegal("trap_illegal_set", 1'b1);
            step("trap_outputs", ZERO);
        end
        rst = 1'b1;
        check_illegal("trap_illegal_in_reset", 1'b1);
        step("trap_reset_cycle", ZERO);
        rst = 1'b0;
        check_illegal("trap_illegal_cleared", 1'b0);
        step("trap_post_reset_fetch", FETCH_GO);
`else
        check_illegal("nop_illegal_low", 1'b0);
        step("nop_back_to_fetch", FETCH_GO);
        check_illegal("nop_illegal_still_low", 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencing controller for the MIPS-subset datapath. It replaces the single-cycle decode with a registered state machine that steps each instruction through fetch, decode, execute, memory and writeback. A single shared memory port is held with a req/ready handshake. All datapath enables and muxes are driven as Moore outputs of the current state, plus opcode/funct where noted.

## Interface
- Parameters: none.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current request.
- mem_req  out  1  memory access request.
- mem_write  out  1  request is a store.
- i_or_d  out  1  address mux: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_en  out  1  PC load: pc_write | (branch & zero).
- pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback data is from memory.
- reg_write  out  1  register file write.
- reg_src  out  1  alternate writeback source (MOVS).
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- States:
  - FETCH
  - DECODE
  - MEMADR
  - MEMRD
  - MEMWB
  - MEMWR
  - EXEC
  - ALUWB
  - BRANCH
  - ADDIEX
  - ADDIWB
  - JUMP
  - MOVWB
  - TRAP (macro only)
- FETCH:
  - Asserts mem_req with i_or_d=0, alu_src_a=0, alu_src_b=01, add, pc_src=00.
  - Stays while mem_ready=0.
  - On mem_ready=1, asserts ir_write and pc_write in that same cycle, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - 010000 → MOVWB
  - other → FETCH (illegal)
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, i_or_d=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
- MEMWR: mem_req=1, mem_write=1, i_or_d=1. Waits for mem_ready. instr_done is asserted in the mem_ready cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct:
  - 100000 add
  - 100010 sub
  - 100100 and
  - 100101 or
  - 101010 slt
  - other add
- ALUWB: reg_write=1, reg_dst=1, instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, instr_done=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, add.
- ADDIWB: reg_write=1, reg_dst=0, instr_done=1.
- JUMP: pc_write=1, pc_src=10, instr_done=1.
- MOVWB: reg_write=1, reg_src=1, reg_dst=0, instr_done=1.
- Every final state returns to FETCH.
- Any output not listed for a state is 0.

## Timing
- State register updates on the rising edge.
- Outputs are combinational from state, opcode and funct. No output is registered except illegal_op.
- Cycle counts with zero wait (mem_ready high in the first request cycle):
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - addi 4
  - j 3
  - MOVS 3
- Each wait cycle adds exactly one cycle.
- Handshake:
  - mem_req stays high and all request signals stay stable until the cycle in which mem_ready=1. That cycle completes the transfer.
  - mem_ready while mem_req=0 is ignored.
- Reset:
  - While rst=1, every output is forced to 0, except illegal_op, which is cleared on the edge.
  - The edge with rst=1 loads FETCH.
  - The first cycle after deassertion is FETCH with mem_req=1.
  - Reset mid-instruction or mid-wait abandons the instruction. No writes occur in or after the reset cycle.

## Configuration
- MC_ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP sets illegal_op=1, holds all other outputs 0, and stays until reset.
- MC_ILLEGAL_TRAP_EN undefined:
  - An unknown opcode is a 2-cycle NOP back to FETCH.
  - illegal_op is tied to 0.
  - TRAP is not compiled.

## Structure
- Package `mc_pkg` holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_MOVS)
  - funct constants
  - ALU control codes
  - alu_src_b and pc_src encodings
- Sub-module `alu_decoder` (combinational): inputs alu_op[1:0] and funct, output alu_control. The FSM drives alu_op as 00 add, 01 sub, 10 funct-driven.

## Test plan
- Reset, then R-type add (opcode 000000, funct 100000), mem_ready tied 1:
  - States FETCH, DECODE, EXEC, ALUWB; alu_control=010 in EXEC.
  - reg_write=1 with reg_dst=1 in cycle 4; instr_done pulses once.
- lw with mem_ready held low for 3 cycles in MEMRD:
  - mem_req=1 and i_or_d=1 stable for 4 cycles; total 8 cycles.
  - MEMWB asserts mem_to_reg=1, reg_write=1.
- beq with zero=1, then zero=0:
  - BRANCH gives pc_en=1, pc_src=01 in the first case and pc_en=0 in the second; both take 3 cycles.
- j, addi, MOVS back-to-back:
  - JUMP: pc_src=10, pc_en=1.
  - ADDIWB: alu_src_b=10 in ADDIEX, reg_dst=0.
  - MOVWB: reg_src=1.
- rst pulsed during a MEMWR wait:
  - mem_req and mem_write drop to 0 in the reset cycle.
  - Next cycle is FETCH; no reg_write or mem_write completes.
- Opcode 111111:
  - With macro: TRAP, illegal_op=1 held through further clocks until rst.
  - Without macro: FETCH after DECODE; illegal_op=0.
